stream_demux_1xn: RTL and testbench
===================================

Name: stream_demux_1xn

Overview:
Parametrised 1-to-N stream demultiplexer with a registered output stage and valid/ready handshake on every port. It routes beats from one upstream stream to one of N_OUT downstream streams. Routing is packet-aware: the select is captured on the first beat of a packet and held until the beat carrying s_last is accepted. Out-of-range selects are dropped and counted. It sits between a single source (parser, DMA) and per-channel consumers in the data-routing path.

Parameters:
DATA_W, 8, payload width in bits
N_OUT, 4, number of output channels, 2..16
SEL_W, 2, select width; must satisfy 2**SEL_W >= N_OUT
CNT_W, 16, width of the drop counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
s_data  input  DATA_W  upstream payload
s_sel  input  SEL_W  destination channel, sampled only on the first beat of a packet
s_last  input  1  final beat of the packet
s_valid  input  1  upstream beat valid
s_ready  output  1  upstream beat accepted this cycle when s_valid && s_ready
m_data  output  DATA_W  registered payload, shared by all channels
m_last  output  1  registered last flag, shared
m_valid  output  N_OUT  per-channel valid; at most one bit set (one-hot or zero)
m_ready  input  N_OUT  per-channel downstream ready
busy  output  1  high while a multi-beat packet is in progress (state PKT)
drop_cnt  output  CNT_W  saturating count of dropped beats

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; out_vld=0.
  - m_valid=0, m_data=0, m_last=0, busy=0, drop_cnt=0.
  - lock_sel=0; any packet in progress is abandoned.
- Effective select: eff_sel = (state==PKT) ? lock_sel : s_sel.
- Drop condition: drop = (eff_sel >= N_OUT).
- Output register: holds out_vld, out_data, out_last, out_sel.
  - m_valid[i] = out_vld && (out_sel==i).
  - m_data = out_data and m_last = out_last, driven onto all channels.
- Handshake:
  - s_ready = drop ? 1 : (!out_vld || m_ready[out_sel]). This path is combinational from m_ready and s_sel.
  - A non-dropped accepted beat loads the output register on the next edge, giving 1-cycle latency from acceptance to m_valid.
  - The output register clears when m_valid[out_sel] && m_ready[out_sel] and no new beat loads in the same cycle.
  - Simultaneous output drain and input load is required; sustained throughput is one beat per clock.
  - m_data, m_last and m_valid hold stable while m_valid is set and m_ready is low.
  - m_ready bits of channels whose m_valid is low are ignored.
- Dropped beat: accepted without loading the register; output state is untouched; drop_cnt += 1, saturating at all-ones.
- FSM, updated on every accepted beat, dropped or not:
  - IDLE, s_last=0: go to PKT, lock_sel <= s_sel.
  - IDLE, s_last=1: stay in IDLE (single-beat packet).
  - PKT, s_last=0: stay in PKT; s_sel is ignored.
  - PKT, s_last=1: go to IDLE.
  - A dropped packet still walks the FSM, so all of its beats are dropped.
- busy = (state==PKT), registered.
- s_valid low, or s_valid high without s_ready: no state change.
- Behaviour is undefined if s_data, s_sel or s_last change while s_valid && !s_ready. The upstream must hold them stable.

Test Plan:
- Reset and idle: assert rst for 2 cycles with s_valid=1 -> m_valid=0, drop_cnt=0, busy=0 throughout; s_ready only evaluated after reset releases.
- Single-beat routing: with m_ready=4'b1111, send beats to sel=0,1,2,3 (data 0x11,0x22,0x33,0x44, last=1) back-to-back -> m_valid = 0001,0010,0100,1000 on consecutive cycles, one cycle after each accept; matching data; s_ready held at 1.
- Packet lock: 3-beat packet with sel=2 on beat 0 and s_sel changed to 1 then 3 on beats 1-2 -> all three beats appear on channel 2; busy=1 after beat 0; busy=0 after the last beat is accepted.
- Backpressure: m_ready[1]=0 for 5 cycles with a beat pending on channel 1 -> m_valid=0010 and data held stable; s_ready=0 for a following beat; release m_ready -> that beat appears next cycle with no loss or duplication.
- Drop and saturation: N_OUT=3, send a 4-beat packet with sel=3 -> s_ready=1, m_valid stays 0, drop_cnt=4; with CNT_W=4, push 20 dropped beats -> drop_cnt saturates at 4'hF.
- Reset mid-packet: assert rst after beat 1 of a 4-beat packet with sel=1 -> busy=0, m_valid=0; next beat with sel=3 and last=1 routes to channel 3.

Source files
------------

// File: rtl/stream_demux_1xn.sv
// 1-to-N packet-aware stream demultiplexer with a registered output stage.
// The select locks on the first beat of a packet; out-of-range packets are dropped and counted.
module stream_demux_1xn #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic [SEL_W-1:0]  s_sel,
  input  logic              s_last,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [N_OUT-1:0]  m_valid,
  input  logic [N_OUT-1:0]  m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic {IDLE, PKT} state_t;

  localparam logic [SEL_W:0] NOUT_X = (SEL_W+1)'(N_OUT);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  lock_sel_q, lock_sel_d;
  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic [SEL_W-1:0]  eff_sel;
  logic              drop, acc, load, out_rdy;

  assign eff_sel = (state_q == PKT) ? lock_sel_q : s_sel;
  assign drop    = ({1'b0, eff_sel} >= NOUT_X);

  for (genvar i = 0; i < N_OUT; i++) begin : g_vld
    assign m_valid[i] = out_vld_q && (out_sel_q == SEL_W'(i));
  end

  // m_valid is one-hot, so this is m_ready[out_sel] gated by out_vld without an out-of-range index.
  assign out_rdy = |(m_valid & m_ready);
  assign s_ready = drop || !out_vld_q || out_rdy;
  assign acc     = s_valid && s_ready;
  assign load    = acc && !drop;

  assign m_data   = out_data_q;
  assign m_last   = out_last_q;
  assign busy     = (state_q == PKT);
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    if (acc) begin
      case (state_q)
        IDLE: if (!s_last) begin
          state_d    = PKT;
          lock_sel_d = s_sel;
        end
        PKT:  if (s_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    out_sel_d  = out_sel_q;
    drop_cnt_d = drop_cnt_q;
    if (load) begin
      out_vld_d  = 1'b1;
      out_data_d = s_data;
      out_last_d = s_last;
      out_sel_d  = eff_sel;
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end
    if (acc && drop && (drop_cnt_q != {CNT_W{1'b1}}))
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_sel_q <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_sel_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_sel_q  <= out_sel_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Bench for stream_demux_1xn: a 4-channel instance for routing/locking/backpressure,
// and a 3-channel, 4-bit-counter instance for drop and saturation behaviour.
module tb_stream_demux_1xn;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic       clk, rst;
  logic [7:0] s_data;
  logic [1:0] s_sel;
  logic       s_last, s_valid, s_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic [3:0] m_valid, m_ready;
  logic       busy;
  logic [15:0] drop_cnt;

  logic [7:0] b_s_data;
  logic [1:0] b_s_sel;
  logic       b_s_last, b_s_valid, b_s_ready;
  logic [7:0] b_m_data;
  logic       b_m_last;
  logic [2:0] b_m_valid, b_m_ready;
  logic       b_busy;
  logic [3:0] b_drop_cnt;

  int checks = 0;
  int failures = 0;

  beat_t exp_q[$];
  beat_t obs_q[$];
  logic       tb_pkt = 1'b0;
  logic [1:0] tb_lock = 2'd0;

  stream_demux_1xn #(.DATA_W(8), .N_OUT(4), .SEL_W(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_sel(s_sel), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .drop_cnt(drop_cnt)
  );

  stream_demux_1xn #(.DATA_W(8), .N_OUT(3), .SEL_W(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .s_data(b_s_data), .s_sel(b_s_sel), .s_last(b_s_last),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .m_data(b_m_data), .m_last(b_m_last),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .busy(b_busy), .drop_cnt(b_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every downstream handshake of the 4-channel instance.
  always @(negedge clk) begin
    if (m_valid != 4'b0) begin
      checks++;
      if (!$onehot(m_valid)) begin
        failures++;
        $display("FAIL onehot m_valid=%b", m_valid);
      end
    end
    if (|(m_valid & m_ready)) begin
      beat_t o;
      o.sel = 2'd0;
      for (int i = 0; i < 4; i++) if (m_valid[i]) o.sel = 2'(i);
      o.data = m_data;
      o.last = m_last;
      obs_q.push_back(o);
    end
  end

  // Present a beat (inputs held) until accepted; returns at posedge+1 after acceptance.
  task automatic send(input logic [1:0] sel, input logic [7:0] d, input logic l);
    logic acc;
    logic [1:0] esel;
    beat_t e;
    s_valid = 1'b1; s_sel = sel; s_data = d; s_last = l;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (s_ready === 1'b1) acc = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_timeout sel=%0d data=%h never accepted", sel, d);
    end else begin
      esel = tb_pkt ? tb_lock : sel;
      e.sel = esel; e.data = d; e.last = l;
      exp_q.push_back(e);
      if (!tb_pkt && !l) begin
        tb_pkt = 1'b1;
        tb_lock = sel;
      end else if (tb_pkt && l) begin
        tb_pkt = 1'b0;
      end
    end
  endtask

  task automatic idle_drain();
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b1; s_sel = 2'd0; s_data = 8'hAA; s_last = 1'b0;
    m_ready = 4'b1111;
    b_s_valid = 1'b0; b_s_sel = 2'd0; b_s_data = 8'h00; b_s_last = 1'b0;
    b_m_ready = 3'b111;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (m_valid !== 4'b0 || busy !== 1'b0 || drop_cnt !== 16'd0 ||
          m_data !== 8'h00 || m_last !== 1'b0) begin
        failures++;
        $display("FAIL reset_state m_valid=%b busy=%b drop_cnt=%0d m_data=%h m_last=%b expected 0",
                 m_valid, busy, drop_cnt, m_data, m_last);
      end
      checks++;
      if (b_m_valid !== 3'b0 || b_busy !== 1'b0 || b_drop_cnt !== 4'd0) begin
        failures++;
        $display("FAIL reset_state_b m_valid=%b busy=%b drop_cnt=%0d expected 0",
                 b_m_valid, b_busy, b_drop_cnt);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    s_valid = 1'b0;
    tb_pkt = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 4'b0) begin
      failures++;
      $display("FAIL post_reset s_ready=%b m_valid=%b expected 1/0000", s_ready, m_valid);
    end
  endtask

  task automatic test_routing();
    logic [7:0] dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    beat_t e, o;
    m_ready = 4'b1111;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      send(2'(k), dat[k], 1'b1);
      checks++;
      if (m_valid !== 4'(1 << k) || m_data !== dat[k] || m_last !== 1'b1) begin
        failures++;
        $display("FAIL routing_%0d m_valid=%b m_data=%h m_last=%b expected %b/%h/1",
                 k, m_valid, m_data, m_last, 4'(1 << k), dat[k]);
      end
    end
    idle_drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL routing_count observed=%0d expected=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL routing_sb got sel=%0d data=%h last=%b expected sel=%0d data=%h last=%b",
                 o.sel, o.data, o.last, e.sel, e.data, e.last);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_packet_lock();
    beat_t e, o;
    m_ready = 4'b1111;
    send(2'd2, 8'h51, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL lock_busy_set busy=%b expected 1", busy);
    end
    send(2'd1, 8'h52, 1'b0);
    send(2'd3, 8'h53, 1'b1);
    checks++;
    if (busy !== 1'b0 || m_valid !== 4'b0100) begin
      failures++;
      $display("FAIL lock_end busy=%b m_valid=%b expected 0/0100", busy, m_valid);
    end
    idle_drain();
    checks++;
    if (obs_q.size() != 3 || exp_q.size() != 3) begin
      failures++;
      $display("FAIL lock_count observed=%0d expected=3", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e || o.sel !== 2'd2) begin
        failures++;
        $display("FAIL lock_sb got sel=%0d data=%h last=%b expected sel=2 data=%h last=%b",
                 o.sel, o.data, o.last, e.data, e.last);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    beat_t e, o;
    m_ready = 4'b1101;
    send(2'd1, 8'h61, 1'b1);
    s_valid = 1'b1; s_sel = 2'd0; s_data = 8'h62; s_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 4'b0010 || m_data !== 8'h61 || s_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d m_valid=%b m_data=%h s_ready=%b expected 0010/61/0",
                 c, m_valid, m_data, s_ready);
      end
      @(posedge clk); #1;
    end
    m_ready = 4'b1111;
    send(2'd0, 8'h62, 1'b1);
    checks++;
    if (m_valid !== 4'b0001 || m_data !== 8'h62) begin
      failures++;
      $display("FAIL bp_release m_valid=%b m_data=%h expected 0001/62", m_valid, m_data);
    end
    idle_drain();
    checks++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      failures++;
      $display("FAIL bp_count observed=%0d expected=2", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL bp_sb got sel=%0d data=%h expected sel=%0d data=%h",
                 o.sel, o.data, e.sel, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_packet();
    beat_t e, o;
    m_ready = 4'b1111;
    send(2'd1, 8'h71, 1'b0);
    send(2'd1, 8'h72, 1'b0);
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tb_pkt = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || m_valid !== 4'b0) begin
      failures++;
      $display("FAIL midrst_state busy=%b m_valid=%b expected 0/0000", busy, m_valid);
    end
    @(posedge clk); #1;
    send(2'd3, 8'h73, 1'b1);
    checks++;
    if (m_valid !== 4'b1000 || m_data !== 8'h73) begin
      failures++;
      $display("FAIL midrst_route m_valid=%b m_data=%h expected 1000/73", m_valid, m_data);
    end
    idle_drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL midrst_count observed=%0d expected=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL midrst_sb got sel=%0d data=%h expected sel=%0d data=%h",
                 o.sel, o.data, e.sel, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_drop_saturation();
    logic [1:0] sels [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    logic       lsts [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    b_m_ready = 3'b111;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      b_s_valid = 1'b1; b_s_sel = sels[k]; b_s_data = 8'(8'h80 + k); b_s_last = lsts[k];
      @(negedge clk);
      checks++;
      if (b_s_ready !== 1'b1 || b_m_valid !== 3'b0) begin
        failures++;
        $display("FAIL drop_beat_%0d s_ready=%b m_valid=%b expected 1/000", k, b_s_ready, b_m_valid);
      end
      @(posedge clk); #1;
    end
    b_s_valid = 1'b0;
    checks++;
    if (b_drop_cnt !== 4'd4 || b_busy !== 1'b0 || b_m_valid !== 3'b0) begin
      failures++;
      $display("FAIL drop_count cnt=%0d busy=%b m_valid=%b expected 4/0/000",
               b_drop_cnt, b_busy, b_m_valid);
    end
    for (int k = 0; k < 16; k++) begin
      b_s_valid = 1'b1; b_s_sel = 2'd3; b_s_data = 8'(k); b_s_last = 1'b1;
      @(posedge clk); #1;
    end
    b_s_valid = 1'b0;
    checks++;
    if (b_drop_cnt !== 4'hF || b_m_valid !== 3'b0) begin
      failures++;
      $display("FAIL drop_saturate cnt=%h m_valid=%b expected F/000", b_drop_cnt, b_m_valid);
    end
    b_s_valid = 1'b1; b_s_sel = 2'd2; b_s_data = 8'h99; b_s_last = 1'b1;
    @(posedge clk); #1;
    b_s_valid = 1'b0;
    checks++;
    if (b_m_valid !== 3'b100 || b_m_data !== 8'h99 || b_drop_cnt !== 4'hF) begin
      failures++;
      $display("FAIL drop_then_route m_valid=%b m_data=%h cnt=%h expected 100/99/F",
               b_m_valid, b_m_data, b_drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_packet_lock();
    test_backpressure();
    test_reset_mid_packet();
    test_drop_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
